am2910_sequencer: RTL
=====================

// Module: am2910_sequencer
// PURPOSE
//  Am2910-compatible microprogram sequencer core. Registers the state that the
//  combinational instruction decoder steers:
//  - microprogram counter (uPC)
//  - register/counter R
//  - STACK_DEPTH-entry LIFO stack with pointer
//  Each cycle it presents next microaddress Y to control store; sits between pipeline register (I, D, CC) and control ROM.
// PARAMETERS
//  ADDR_W       12  microaddress / D / R / stack entry width
//  STACK_DEPTH  5   number of stack entries (>=2)
// PORTS
//  clk     in   1       single clock, rising edge
//  rst     in   1       asynchronous, active-high reset
//  i       in   4       instruction (JZ..TWB encoding, 4'h0..4'hF)
//  d       in   ADDR_W  direct input: branch address / counter load value
//  cc_n    in   1       condition code, active low
//  ccen_n  in   1       condition enable, active low; 1 forces test pass
//  ci      in   1       uPC incrementer carry-in
//  rld_n   in   1       active-low unconditional R load from d
//  y       out  ADDR_W  next microaddress (combinational)
//  full_n  out  1       low when stack holds STACK_DEPTH entries
//  pl_n    out  1       pipeline-register enable (active low)
//  map_n   out  1       mapping-PROM enable (active low)
//  vect_n  out  1       vector enable (active low)
// BEHAVIOUR
//  - Test: test_passed = ccen_n | ~cc_n. R_is_zero = (R == 0).
//  - Decoder yields mux_sel, push, pop, clear, r_load, r_dec and enables.
//    pl_n/map_n/vect_n are the decoder outputs passed straight through.
//  - y mux (same cycle, no latency):
//    - PC -> uPC
//    - F  -> stack top (0 when empty)
//    - D  -> d
//    - R  -> R
//  - On each rising clk edge:
//    - uPC <= y + ci, mod 2^ADDR_W; 'hFFF+1 wraps to 0.
//    - R: load d if (!rld_n | r_load). Else R-1 if r_dec. Load wins over dec.
//      R never decrements below 0; decoder only decs when R != 0.
//    - Stack: clear sets sp=0. Otherwise push writes *pre-edge* uPC at stack[sp]
//      and sp++. Pop does sp--. Push and pop never both asserted by the decoder.
//  - full_n = ~(sp == STACK_DEPTH), combinational from sp.
//  - Boundaries:
//    - Push when full: overwrite top entry (stack[STACK_DEPTH-1]); sp holds.
//    - Pop when empty: sp holds at 0; F reads 0.
//    - JZ: y = d, sp = 0; R unchanged.
//    - rld_n=0 during RFCT/RPCT/TWB: load overrides dec; y still uses pre-edge R_is_zero.
//  - Reset (async, any time incl. mid-loop): uPC=0, R=0, sp=0, all stack entries=0.
//    y then follows i/d combinationally; full_n=1 immediately.
//  - No internal FSM beyond uPC/R/sp; all sequencing comes from i each cycle.
// STRUCTURE
//  - Shared package am2910_pkg:
//    - opcode localparams JZ..TWB
//    - mux select codes MUX_SEL_PC/F/D/R
//    - ADDR_W default
//  - Single sub-module: instruction_decoder (existing, instantiated unchanged).
//  - Stack as register array plus clog2(STACK_DEPTH+1)-bit pointer. No RAM macro.
// TESTING
//  1 Reset, i=CONT, ci=1, 4 clocks -> y sequence 0,1,2,3; full_n=1.
//  2 uPC=0x010, CJS, d=0x200, cc_n=0, ccen_n=0 -> y=0x200, sp=1, stack[0]=0x010.
//    Next cycle CRTN, cc_n=0 -> y=0x010, sp=0.
//  3 LDCT, d=3, then RPCT, d=0x080 x4:
//    - first 3 cycles y=0x080, R=2,1,0
//    - 4th cycle y=uPC, R stays 0
//  4 Six CJS pushes, uPC=1..6:
//    - full_n=0 after 5th push
//    - 6th push overwrites stack[4]=6, sp=5
//    - JZ, d=0 -> y=0, full_n=1
//  5 Pop on empty (CRTN, test pass) -> y=0, sp=0.
//    uPC=0xFFF, CONT, ci=1 -> next uPC=0x000.
//  6 Push 0x040, R=2, TWB with cc_n=1, ccen_n=0:
//    - y=0x040 twice (R=1,0)
//    - then y=d with pop
//    - assert rst mid-sequence -> uPC/R/sp = 0 at once

Source files
------------

// File: rtl/am2910_pkg.sv
// Shared definitions for the Am2910-compatible microprogram sequencer.
// Contents:
//   ADDR_W_DEFAULT  default microaddress width
//   JZ..TWB         4-bit instruction encodings
//   mux_sel_t       Y output multiplexer select codes
//   dec_ctl_t       control bundle produced by the instruction decoder
package am2910_pkg;

  localparam int ADDR_W_DEFAULT = 12;

  // Instruction encodings
  localparam logic [3:0] JZ   = 4'h0;
  localparam logic [3:0] CJS  = 4'h1;
  localparam logic [3:0] JMAP = 4'h2;
  localparam logic [3:0] CJP  = 4'h3;
  localparam logic [3:0] PUSH = 4'h4;
  localparam logic [3:0] JSRP = 4'h5;
  localparam logic [3:0] CJV  = 4'h6;
  localparam logic [3:0] JRP  = 4'h7;
  localparam logic [3:0] RFCT = 4'h8;
  localparam logic [3:0] RPCT = 4'h9;
  localparam logic [3:0] CRTN = 4'hA;
  localparam logic [3:0] CJPP = 4'hB;
  localparam logic [3:0] LDCT = 4'hC;
  localparam logic [3:0] LOOP = 4'hD;
  localparam logic [3:0] CONT = 4'hE;
  localparam logic [3:0] TWB  = 4'hF;

  // Y multiplexer sources
  typedef enum logic [1:0] {
    MUX_SEL_PC = 2'd0,
    MUX_SEL_R  = 2'd1,
    MUX_SEL_F  = 2'd2,
    MUX_SEL_D  = 2'd3
  } mux_sel_t;

  // Everything the datapath needs from the decoder for one cycle
  typedef struct packed {
    mux_sel_t mux_sel;
    logic     push;
    logic     pop;
    logic     clear;
    logic     r_load;
    logic     r_dec;
    logic     pl_n;
    logic     map_n;
    logic     vect_n;
  } dec_ctl_t;

endpackage

// File: rtl/am2910_sequencer_if.sv
// Bus between the pipeline register / control store and the sequencer.
// Signals:
//   i, d, cc_n, ccen_n, ci, rld_n   pipeline side -> sequencer
//   y, full_n, pl_n, map_n, vect_n  sequencer -> control store / enables
// Modports:
//   master  pipeline/control-store side
//   slave   the sequencer core
interface am2910_sequencer_if
  import am2910_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);

  logic [3:0]        i;
  logic [ADDR_W-1:0] d;
  logic              cc_n;
  logic              ccen_n;
  logic              ci;
  logic              rld_n;
  logic [ADDR_W-1:0] y;
  logic              full_n;
  logic              pl_n;
  logic              map_n;
  logic              vect_n;

  modport master (
    output i, d, cc_n, ccen_n, ci, rld_n,
    input  y, full_n, pl_n, map_n, vect_n
  );

  modport slave (
    input  i, d, cc_n, ccen_n, ci, rld_n,
    output y, full_n, pl_n, map_n, vect_n
  );

endinterface

// File: rtl/am2910_sequencer_instruction_decoder.sv
// Combinational Am2910 instruction decoder.
// Ports:
//   i            in   4-bit instruction
//   test_passed  in   condition test result (ccen_n | ~cc_n)
//   r_is_zero    in   register/counter R equals zero
//   ctl          out  mux select, stack/R controls and enable outputs
module instruction_decoder
  import am2910_pkg::*;
(
  input  logic [3:0] i,
  input  logic       test_passed,
  input  logic       r_is_zero,
  output dec_ctl_t   ctl
);

  // One case arm per instruction; defaults describe a plain CONT with the
  // pipeline register enabled.
  always_comb begin
    ctl         = '0;
    ctl.mux_sel = MUX_SEL_PC;
    ctl.pl_n    = 1'b0;
    ctl.map_n   = 1'b1;
    ctl.vect_n  = 1'b1;
    case (i)
      JZ: begin
        ctl.mux_sel = MUX_SEL_D;
        ctl.clear   = 1'b1;
      end
      CJS: begin
        if (test_passed) begin
          ctl.mux_sel = MUX_SEL_D;
          ctl.push    = 1'b1;
        end
      end
      JMAP: begin
        ctl.mux_sel = MUX_SEL_D;
        ctl.pl_n    = 1'b1;
        ctl.map_n   = 1'b0;
      end
      CJP: begin
        if (test_passed) ctl.mux_sel = MUX_SEL_D;
      end
      PUSH: begin
        ctl.push   = 1'b1;
        ctl.r_load = test_passed;
      end
      JSRP: begin
        ctl.push    = 1'b1;
        ctl.mux_sel = test_passed ? MUX_SEL_D : MUX_SEL_R;
      end
      CJV: begin
        ctl.pl_n   = 1'b1;
        ctl.vect_n = 1'b0;
        if (test_passed) ctl.mux_sel = MUX_SEL_D;
      end
      JRP: begin
        ctl.mux_sel = test_passed ? MUX_SEL_D : MUX_SEL_R;
      end
      RFCT: begin
        // Loop back to the stacked address until R runs out, then fall through
        if (!r_is_zero) begin
          ctl.mux_sel = MUX_SEL_F;
          ctl.r_dec   = 1'b1;
        end else begin
          ctl.pop = 1'b1;
        end
      end
      RPCT: begin
        if (!r_is_zero) begin
          ctl.mux_sel = MUX_SEL_D;
          ctl.r_dec   = 1'b1;
        end
      end
      CRTN: begin
        if (test_passed) begin
          ctl.mux_sel = MUX_SEL_F;
          ctl.pop     = 1'b1;
        end
      end
      CJPP: begin
        if (test_passed) begin
          ctl.mux_sel = MUX_SEL_D;
          ctl.pop     = 1'b1;
        end
      end
      LDCT: begin
        ctl.r_load = 1'b1;
      end
      LOOP: begin
        if (test_passed) ctl.pop = 1'b1;
        else             ctl.mux_sel = MUX_SEL_F;
      end
      CONT: begin
      end
      TWB: begin
        // Exit on pass; otherwise loop while R counts down, branch to D when exhausted
        if (test_passed) begin
          ctl.pop = 1'b1;
        end else if (!r_is_zero) begin
          ctl.mux_sel = MUX_SEL_F;
          ctl.r_dec   = 1'b1;
        end else begin
          ctl.mux_sel = MUX_SEL_D;
          ctl.pop     = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/am2910_sequencer.sv
// Am2910-compatible microprogram sequencer core: holds uPC, register/counter R
// and a STACK_DEPTH-entry LIFO, and presents the next microaddress y each cycle.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   slave side of am2910_sequencer_if (i, d, cc_n, ccen_n, ci, rld_n in;
//         y, full_n, pl_n, map_n, vect_n out)
module am2910_sequencer
  import am2910_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int STACK_DEPTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  am2910_sequencer_if.slave  bus
);

  localparam int             SP_W    = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] upc;
  logic [ADDR_W-1:0] r_reg;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp;

  logic              test_passed;
  logic              r_is_zero;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] y_next;
  dec_ctl_t          ctl;

  assign test_passed = bus.ccen_n | ~bus.cc_n;
  assign r_is_zero   = (r_reg == '0);

  // An empty stack reads as zero so a stray return lands on address 0
  assign stack_top = (sp == '0) ? '0 : stack_mem[sp - SP_W'(1)];

  instruction_decoder u_decoder (
    .i           (bus.i),
    .test_passed (test_passed),
    .r_is_zero   (r_is_zero),
    .ctl         (ctl)
  );

  always_comb begin
    y_next = upc;
    case (ctl.mux_sel)
      MUX_SEL_PC: y_next = upc;
      MUX_SEL_R:  y_next = r_reg;
      MUX_SEL_F:  y_next = stack_top;
      MUX_SEL_D:  y_next = bus.d;
      default:    y_next = upc;
    endcase
  end

  assign bus.y      = y_next;
  assign bus.full_n = (sp != SP_FULL);
  assign bus.pl_n   = ctl.pl_n;
  assign bus.map_n  = ctl.map_n;
  assign bus.vect_n = ctl.vect_n;

  // uPC tracks the address just issued plus carry-in, wrapping naturally.
  // An external rld_n load takes priority over a decoder-driven decrement.
  // Pushes save the uPC as it stands before this edge (the return address);
  // a push into a full stack overwrites the top entry instead of growing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upc   <= '0;
      r_reg <= '0;
      sp    <= '0;
      for (int k = 0; k < STACK_DEPTH; k++) begin
        stack_mem[k] <= '0;
      end
    end else begin
      upc <= y_next + ADDR_W'(bus.ci);

      if (!bus.rld_n || ctl.r_load) begin
        r_reg <= bus.d;
      end else if (ctl.r_dec && !r_is_zero) begin
        r_reg <= r_reg - ADDR_W'(1);
      end

      if (ctl.clear) begin
        sp <= '0;
      end else if (ctl.push) begin
        if (sp == SP_FULL) begin
          stack_mem[STACK_DEPTH-1] <= upc;
        end else begin
          stack_mem[sp] <= upc;
          sp            <= sp + SP_W'(1);
        end
      end else if (ctl.pop && (sp != '0)) begin
        sp <= sp - SP_W'(1);
      end
    end
  end

endmodule
